// File: rtl/lbr_unit_pkg.sv
// Shared definitions for the last-branch-record unit: request encodings from the
// control unit and control-register bit positions.
package lbr_unit_pkg;

    typedef enum logic [1:0] {
        LBR_REQ_NONE  = 2'b00,
        LBR_REQ_RSVD  = 2'b01,
        LBR_REQ_READ  = 2'b10,
        LBR_REQ_WRITE = 2'b11
    } lbr_req_e;

    localparam int unsigned LBR_CTL_EN     = 0;
    localparam int unsigned LBR_CTL_FREEZE = 1;
    localparam int unsigned LBR_CTL_CLEAR  = 2;

    localparam logic [1:0] LBR_CTL_RESET = 2'b01;

endpackage

// File: rtl/lbr_ring_buffer.sv
// Circular (from, to) history with age-indexed, one-cycle registered read port.
module lbr_ring_buffer
    import lbr_unit_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic                     i_rec,
    input  logic [DW-1:0]            i_rec_from,
    input  logic [DW-1:0]            i_rec_to,
    input  logic                     i_rd,
    input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
    input  logic                     i_rd_oob,
    input  logic                     i_rd_sel,
    output logic [DW-1:0]            o_rdata,
    output logic                     o_rdata_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [IW:0] FULL = DEPTH[IW:0];

    logic [DW-1:0] r_from [DEPTH];
    logic [DW-1:0] r_to   [DEPTH];
    logic [IW-1:0] r_head;
    logic [IW:0]   r_count;
    logic [DW-1:0] r_rdata;
    logic          r_rdata_valid;

    logic [IW-1:0] w_slot;
    logic          w_hit;

    // Age 0 is the slot just behind head; natural wrap of the IW-bit subtraction.
    assign w_slot = r_head - IW'(1) - i_rd_idx;
    assign w_hit  = !i_rd_oob && ({1'b0, i_rd_idx} < r_count);

    // Entry contents carry no reset; stale slots are masked by r_count.
    always_ff @(posedge i_clock) begin
        if (i_rec && !i_clear) begin
            r_from[r_head] <= i_rec_from;
            r_to[r_head]   <= i_rec_to;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_head        <= '0;
            r_count       <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= i_rd;
            if (i_rd) begin
                r_rdata <= w_hit ? (i_rd_sel ? r_to[w_slot] : r_from[w_slot]) : '0;
            end
            if (i_clear) begin
                r_head  <= '0;
                r_count <= '0;
            end else if (i_rec) begin
                r_head <= r_head + IW'(1);
                if (r_count != FULL) begin
                    r_count <= r_count + (IW + 1)'(1);
                end
            end
        end
    end

    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_count       = r_count;

endmodule

// File: rtl/lbr_unit.sv
// Last Branch Record unit: decodes RDLBR/WRLBR, owns the control register and
// freeze flag, and logs retired control-flow transfers into the ring buffer.
module lbr_unit
    import lbr_unit_pkg::*;
#(
    parameter int unsigned CORE         = 0,
    parameter int unsigned ADDRESS_BITS = 32,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [1:0]               i_lbr_req,
    input  logic [ADDRESS_BITS-1:0]  i_lbr_arg,
    input  logic                     i_rec_valid,
    input  logic [ADDRESS_BITS-1:0]  i_rec_from,
    input  logic [ADDRESS_BITS-1:0]  i_rec_to,
    output logic [ADDRESS_BITS-1:0]  o_lbr_rdata,
    output logic                     o_lbr_rdata_valid,
    output logic [$clog2(DEPTH):0]   o_lbr_count,
    output logic                     o_lbr_enabled,
    input  logic                     i_report
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic [1:0] r_ctl;
    logic       r_frozen;

    logic       w_rd;
    logic       w_wr;
    logic       w_clear;
    logic       w_rec;
    logic       w_oob;

    assign w_rd    = (i_lbr_req == LBR_REQ_READ);
    assign w_wr    = (i_lbr_req == LBR_REQ_WRITE);
    assign w_clear = w_wr && i_lbr_arg[LBR_CTL_CLEAR];
    // Record is judged on the pre-write ctl/frozen; a clear in the same cycle drops it.
    assign w_rec   = i_rec_valid && r_ctl[LBR_CTL_EN] && !r_frozen && !w_clear;
    assign w_oob   = |i_lbr_arg[ADDRESS_BITS-2:IW];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ctl    <= LBR_CTL_RESET;
            r_frozen <= 1'b0;
        end else if (w_wr) begin
            r_ctl    <= i_lbr_arg[1:0];
            r_frozen <= 1'b0;
        end else if (w_rd && r_ctl[LBR_CTL_FREEZE]) begin
            r_frozen <= 1'b1;
        end
    end

    lbr_ring_buffer #(
        .DW    (ADDRESS_BITS),
        .DEPTH (DEPTH)
    ) u_ring (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_clear       (w_clear),
        .i_rec         (w_rec),
        .i_rec_from    (i_rec_from),
        .i_rec_to      (i_rec_to),
        .i_rd          (w_rd),
        .i_rd_idx      (i_lbr_arg[IW-1:0]),
        .i_rd_oob      (w_oob),
        .i_rd_sel      (i_lbr_arg[ADDRESS_BITS-1]),
        .o_rdata       (o_lbr_rdata),
        .o_rdata_valid (o_lbr_rdata_valid),
        .o_count       (o_lbr_count)
    );

    assign o_lbr_enabled = r_ctl[LBR_CTL_EN];

`ifndef SYNTHESIS
    always_ff @(posedge i_clock) begin
        if (i_report) begin
            $display("LBR core %0d: count=%0d ctl=%b frozen=%0b", CORE, o_lbr_count, r_ctl,
                     r_frozen);
        end
    end
`endif

endmodule

// File: tb/tb_lbr_unit.sv
// Directed plus randomized bench for lbr_unit, checked against a queue-based
// history model (newest entry at the front).
module tb_lbr_unit;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  lbr_req;
    logic [31:0] lbr_arg;
    logic        rec_valid;
    logic [31:0] rec_from;
    logic [31:0] rec_to;
    logic [31:0] lbr_rdata;
    logic        lbr_rdata_valid;
    logic [4:0]  lbr_count;
    logic        lbr_enabled;
    logic        report;

    always #5 clk = ~clk;

    lbr_unit #(
        .CORE         (0),
        .ADDRESS_BITS (32),
        .DEPTH        (DEPTH)
    ) dut (
        .i_clock           (clk),
        .i_reset           (reset),
        .i_lbr_req         (lbr_req),
        .i_lbr_arg         (lbr_arg),
        .i_rec_valid       (rec_valid),
        .i_rec_from        (rec_from),
        .i_rec_to          (rec_to),
        .o_lbr_rdata       (lbr_rdata),
        .o_lbr_rdata_valid (lbr_rdata_valid),
        .o_lbr_count       (lbr_count),
        .o_lbr_enabled     (lbr_enabled),
        .i_report          (report)
    );

    typedef struct packed {
        logic [31:0] f;
        logic [31:0] t;
    } ent_t;

    ent_t        hist[$];
    logic [1:0]  m_ctl;
    bit          m_frozen;
    logic [31:0] m_rdata;
    logic        m_valid;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(lbr_rdata_valid), 32'(m_valid));
        check({tag, ".rdata"}, lbr_rdata, m_rdata);
        check({tag, ".count"}, 32'(lbr_count), 32'(hist.size()));
        check({tag, ".en"}, 32'(lbr_enabled), 32'(m_ctl[0]));
    endtask

    task automatic model_reset();
        hist.delete();
        m_ctl    = 2'b01;
        m_frozen = 0;
        m_rdata  = '0;
        m_valid  = 1'b0;
    endtask

    // One clock of stimulus; model advanced from the pre-edge state, then compared.
    task automatic step(input string tag, input logic [1:0] req, input logic [31:0] arg,
                        input logic rv, input logic [31:0] f, input logic [31:0] t);
        logic        rd;
        logic        wr;
        int          idx;
        logic [31:0] exp_rd;
        rd     = (req == 2'b10);
        wr     = (req == 2'b11);
        idx    = int'(arg[3:0]);
        exp_rd = '0;
        if (rd && arg[30:4] == 0 && idx < hist.size())
            exp_rd = arg[31] ? hist[idx].t : hist[idx].f;
        lbr_req   = req;
        lbr_arg   = arg;
        rec_valid = rv;
        rec_from  = f;
        rec_to    = t;
        @(posedge clk);
        #1;
        if (rv && m_ctl[0] && !m_frozen && !(wr && arg[2])) begin
            hist.push_front('{f: f, t: t});
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
        m_valid = rd;
        if (rd) begin
            m_rdata = exp_rd;
            if (m_ctl[1]) m_frozen = 1;
        end
        if (wr) begin
            m_ctl    = arg[1:0];
            m_frozen = 0;
            if (arg[2]) hist.delete();
        end
        check_outputs(tag);
        lbr_req   = 2'b00;
        rec_valid = 1'b0;
    endtask

    task automatic rec(input logic [31:0] f, input logic [31:0] t);
        step("rec", 2'b00, 32'h0, 1'b1, f, t);
    endtask

    task automatic rd(input string tag, input logic [31:0] arg);
        step(tag, 2'b10, arg, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] arg);
        step("wr", 2'b11, arg, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [1:0]  req;
        logic [31:0] arg;
        int          r;
        report    = 1'b0;
        lbr_req   = 2'b00;
        lbr_arg   = '0;
        rec_valid = 1'b0;
        rec_from  = '0;
        rec_to    = '0;
        reset     = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs("reset");

        // Empty buffer read
        rd("empty_rd", 32'h0);
        check("empty_rd.lit", lbr_rdata, 32'h0);

        // Two records, to-PC of newest and from-PC of older
        rec(32'h100, 32'h200);
        rec(32'h300, 32'h400);
        rd("rd_to0", 32'h8000_0000);
        check("rd_to0.lit", lbr_rdata, 32'h400);
        rd("rd_from1", 32'h0000_0001);
        check("rd_from1.lit", lbr_rdata, 32'h100);
        check("count2.lit", 32'(lbr_count), 32'd2);

        // Wrap-around with saturation
        for (int i = 0; i < 20; i++) rec(32'h1000 + 32'(4 * i), 32'h8000 + 32'(i));
        check("full.lit", 32'(lbr_count), 32'd16);
        rd("wrap_idx0", 32'd0);
        check("wrap_idx0.lit", lbr_rdata, 32'h104C);
        rd("wrap_idx15", 32'd15);
        check("wrap_idx15.lit", lbr_rdata, 32'h1010);
        rd("wrap_idx16", 32'd16);
        check("wrap_idx16.lit", lbr_rdata, 32'h0);
        rd("wrap_hi_bits", 32'h0001_0003);

        // Freeze-on-read
        wr(32'd5);
        wr(32'd3);
        rec(32'hA0, 32'hB0);
        rec(32'hA4, 32'hB4);
        rd("frz_rd", 32'd0);
        rec(32'hA8, 32'hB8);
        rec(32'hAC, 32'hBC);
        rec(32'hB0, 32'hC0);
        check("frz_count.lit", 32'(lbr_count), 32'd2);
        wr(32'd1);
        rec(32'hC4, 32'hD4);
        check("resume.lit", 32'(lbr_count), 32'd3);

        // Clear with a simultaneous record: record dropped
        step("clr_rec", 2'b11, 32'd5, 1'b1, 32'hDEAD, 32'hBEEF);
        check("clr_rec.lit", 32'(lbr_count), 32'd0);
        rec(32'h500, 32'h600);
        // Read concurrent with a record sees the prior newest entry
        step("rd_rec", 2'b10, 32'h8000_0000, 1'b1, 32'h700, 32'h800);
        check("rd_rec.lit", lbr_rdata, 32'h600);
        rd("rd_after", 32'h8000_0000);
        check("rd_after.lit", lbr_rdata, 32'h800);
        // Disabled recording and reserved request
        wr(32'd0);
        rec(32'h900, 32'h904);
        step("rsvd", 2'b01, 32'h0, 1'b0, 32'h0, 32'h0);
        wr(32'd1);

        // Randomized mix
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            req = (r < 4) ? 2'b10 : (r < 5) ? 2'b11 : (r < 6) ? 2'b01 : 2'b00;
            arg = $urandom;
            if (req == 2'b10 && $urandom_range(0, 5) != 0) arg[30:4] = '0;
            if (req == 2'b11) begin
                r = $urandom_range(0, 9);
                arg = (r < 6) ? 32'd1 : (r < 8) ? 32'd3 : (r < 9) ? 32'd5 : 32'($urandom_range(0, 7));
            end
            step("rand", req, arg, ($urandom_range(0, 9) < 6), $urandom, $urandom);
        end

        // Reset during a read with a full buffer
        wr(32'd1);
        for (int i = 0; i < 18; i++) rec(32'h2000 + 32'(4 * i), 32'h3000 + 32'(i));
        rd("pre_rst", 32'd0);
        lbr_req = 2'b10;
        lbr_arg = 32'd0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs("rst_rd");
        reset   = 1'b0;
        lbr_req = 2'b00;
        @(posedge clk);
        #1;
        check_outputs("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
